dds_mod_gen: RTL and testbench

Parametrised single-clock symbol modulator for the DDS modulation path. Accepts data symbols over a valid/ready handshake, holds each for a programmable number of clock cycles, and maps the DDS carrier samples to a registered modulated output (ASK, FSK, BPSK, QPSK or raw). It sits between the LFSR/data source and the DAC output mux, with `fsk_sel` feeding the DDS phase-increment select in the top level. Symbol timing is generated internally, replacing the separate slow/fast clock crossing.

---
 rtl/dds_mod_pkg.sv | 22 ++
 rtl/dds_mod_mapper.sv | 53 +++++
 rtl/dds_mod_gen.sv | 93 +++++++++
 tb/tb_dds_mod_gen.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/dds_mod_pkg.sv
// Shared mode codes, FSM encodings and the saturating negate used by the DDS symbol modulator.
// The optional QPSK mapping is controlled by DDS_MOD_QPSK_EN (see dds_mod_mapper).
package dds_mod_pkg;

   localparam logic [1:0] MODE_ASK      = 2'd0;
   localparam logic [1:0] MODE_FSK      = 2'd1;
   localparam logic [1:0] MODE_BPSK     = 2'd2;
   localparam logic [1:0] MODE_QPSK_RAW = 2'd3;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // Negate a w-bit signed value carried in 32 bits; the most-negative code maps to most-positive.
   function automatic logic signed [31:0] sat_neg(input logic signed [31:0] x, input int w);
      logic signed [31:0] min_v;
      min_v = -(32'sd1 <<< (w - 1));
      return (x == min_v) ? ~min_v : -x;
   endfunction

endpackage

// File: rtl/dds_mod_mapper.sv
// Combinational symbol-to-sample mapper. DDS_MOD_QPSK_EN selects QPSK for mode 3,
// otherwise mode 3 is RAW and the cosine path is not built.
module dds_mod_mapper
   import dds_mod_pkg::*;
#(
   parameter int DW = 12
) (
   input  logic signed [DW-1:0] sin_in,
   input  logic signed [DW-1:0] cos_in,
   input  logic        [1:0]    sym,
   input  logic        [1:0]    mode,
   output logic signed [DW-1:0] sample,
   output logic                 fsk_sel
);

   logic signed [DW-1:0] sin_neg;
   logic signed [DW-1:0] mode3_sample;

   assign sin_neg = DW'(sat_neg(32'(sin_in), DW));

`ifdef DDS_MOD_QPSK_EN
   logic signed [DW-1:0] cos_neg;
   logic signed [DW-1:0] i_arm;
   logic signed [DW-1:0] q_arm;
   logic signed [DW:0]   iq_sum;

   // Saturated negation keeps each arm in DW bits, so the DW+1 sum cannot overflow.
   assign cos_neg      = DW'(sat_neg(32'(cos_in), DW));
   assign i_arm        = sym[0] ? cos_in : cos_neg;
   assign q_arm        = sym[1] ? sin_in : sin_neg;
   assign iq_sum       = (DW+1)'(i_arm) + (DW+1)'(q_arm);
   assign mode3_sample = DW'(iq_sum >>> 1);
`else
   logic unused_inputs;
   assign unused_inputs = ^{cos_in, sym[1]};
   assign mode3_sample  = {sym[0], {(DW-1){1'b0}}};
`endif

   always_comb begin
      sample  = '0;
      fsk_sel = 1'b0;
      case (mode)
         MODE_ASK:  sample = sym[0] ? sin_in : '0;
         MODE_FSK: begin
            sample  = sin_in;
            fsk_sel = sym[0];
         end
         MODE_BPSK: sample = sym[0] ? sin_in : sin_neg;
         default:   sample = mode3_sample;
      endcase
   end

endmodule

// File: rtl/dds_mod_gen.sv
// Symbol modulator: valid/ready symbol intake, SYM_DIV-cycle symbol timer and registered output.
// Mode 3 behaviour depends on DDS_MOD_QPSK_EN (QPSK when defined, RAW otherwise).
module dds_mod_gen
   import dds_mod_pkg::*;
#(
   parameter int DW      = 12,
   parameter int SYM_DIV = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic signed [DW-1:0] sin_in,
   input  logic signed [DW-1:0] cos_in,
   input  logic        [1:0]    mode,
   input  logic                 sym_valid,
   input  logic        [1:0]    sym_in,
   output logic                 sym_ready,
   output logic signed [DW-1:0] mod_out,
   output logic                 fsk_sel,
   output logic                 sym_strobe,
   output logic                 underrun
);

   localparam int             CW   = $clog2(SYM_DIV);
   localparam logic [CW-1:0]  LAST = CW'(SYM_DIV - 1);

   state_t               state_reg;
   logic [CW-1:0]        cnt_reg;
   logic [1:0]           sym_reg;
   logic [1:0]           mode_reg;
   logic signed [DW-1:0] map_sample;
   logic                 map_fsk;
   logic                 load;

   dds_mod_mapper #(.DW(DW)) u_mapper (
      .sin_in  (sin_in),
      .cos_in  (cos_in),
      .sym     (sym_reg),
      .mode    (mode_reg),
      .sample  (map_sample),
      .fsk_sel (map_fsk)
   );

   // Ready depends only on state and counter, never on sym_valid.
   assign sym_ready = (state_reg == ST_IDLE) || (cnt_reg == LAST);
   assign load      = sym_valid && sym_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg  <= ST_IDLE;
         cnt_reg    <= '0;
         sym_reg    <= '0;
         mode_reg   <= '0;
         mod_out    <= '0;
         fsk_sel    <= 1'b0;
         sym_strobe <= 1'b0;
         underrun   <= 1'b0;
      end else begin
         sym_strobe <= 1'b0;
         if (state_reg == ST_RUN) begin
            mod_out <= map_sample;
            fsk_sel <= map_fsk;
         end else begin
            mod_out <= '0;
            fsk_sel <= 1'b0;
         end

         if (load) begin
            sym_reg  <= sym_in;
            mode_reg <= mode;
            cnt_reg  <= '0;
         end

         case (state_reg)
            ST_IDLE: begin
               if (load) state_reg <= ST_RUN;
            end
            ST_RUN: begin
               if (cnt_reg == LAST) begin
                  sym_strobe <= 1'b1;
                  if (!load) begin
                     state_reg <= ST_IDLE;
                     underrun  <= 1'b1;
                  end
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dds_mod_gen.sv
// Directed bench for dds_mod_gen (DW=12, SYM_DIV=4); mode-3 expectations follow DDS_MOD_QPSK_EN.
module tb_dds_mod_gen;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic signed [11:0] sin_in = '0;
   logic signed [11:0] cos_in = '0;
   logic [1:0]         mode = '0;
   logic               sym_valid = 1'b0;
   logic [1:0]         sym_in = '0;
   logic               sym_ready;
   logic signed [11:0] mod_out;
   logic               fsk_sel;
   logic               sym_strobe;
   logic               underrun;

   int n_cmp = 0;
   int n_err = 0;

   dds_mod_gen #(.DW(12), .SYM_DIV(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .sin_in     (sin_in),
      .cos_in     (cos_in),
      .mode       (mode),
      .sym_valid  (sym_valid),
      .sym_in     (sym_in),
      .sym_ready  (sym_ready),
      .mod_out    (mod_out),
      .fsk_sel    (fsk_sel),
      .sym_strobe (sym_strobe),
      .underrun   (underrun)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic signed [31:0] got,
                            input logic signed [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check_val({tag, "_mod_out"}, mod_out, 0);
      check_val({tag, "_fsk"}, fsk_sel, 0);
      check_val({tag, "_strobe"}, sym_strobe, 0);
      check_val({tag, "_underrun"}, underrun, 0);
      check_val({tag, "_ready"}, sym_ready, 1);
   endtask

   task automatic do_reset();
      #2 rst = 1'b1;
      #1 check_reset_outputs("rst");
      tick();
      check_val("rst_hold_strobe", sym_strobe, 0);
      rst = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: got 0 expected 1");
      $fatal(1, "timeout");
   end

   initial begin
      logic signed [31:0] m3a, m3b;
      int exp_fsk [3];
      exp_fsk = '{1, 0, 1};
`ifdef DDS_MOD_QPSK_EN
      m3a = -200;
      m3b = 200;
`else
      m3a = 0;
      m3b = -2048;
`endif
      #3 check_reset_outputs("por");
      tick();
      rst = 1'b0;

      // ASK: symbol 1 then symbol 0 offered on the ready cycle
      $display("ASK 1,0 sin=1000");
      mode = 2'd0; sin_in = 12'sd1000; sym_in = 2'b01; sym_valid = 1'b1;
      tick();
      sym_in = 2'b00;
      check_val("ask_ready_busy", sym_ready, 0);
      for (int k = 1; k <= 8; k++) begin
         tick();
         check_val("ask_out", mod_out, (k <= 4) ? 1000 : 0);
         check_val("ask_strobe", sym_strobe, (k == 4 || k == 8) ? 1 : 0);
         check_val("ask_underrun", underrun, (k == 8) ? 1 : 0);
         if (k == 3) check_val("ask_ready_last", sym_ready, 1);
         if (k == 4) sym_valid = 1'b0;
      end
      tick();
      check_val("ask_idle_out", mod_out, 0);
      check_val("ask_idle_ready", sym_ready, 1);

      // BPSK bit 0: saturation, then plain negation
      $display("BPSK 0 sin=-2048/500");
      mode = 2'd2; sym_in = 2'b00; sin_in = -12'sd2048; sym_valid = 1'b1;
      tick();
      sym_valid = 1'b0;
      tick();
      check_val("bpsk_sat", mod_out, 2047);
      check_val("bpsk_fsk", fsk_sel, 0);
      sin_in = 12'sd500;
      for (int k = 2; k <= 4; k++) begin
         tick();
         check_val("bpsk_neg", mod_out, -500);
      end
      tick();
      check_val("bpsk_idle", mod_out, 0);

      // FSK 1,0,1 back-to-back
      $display("FSK 1,0,1");
      do_reset();
      mode = 2'd1; sym_in = 2'b01; sym_valid = 1'b1;
      tick();
      sym_in = 2'b00;
      for (int k = 1; k <= 12; k++) begin
         sin_in = 12'(37 * k);
         tick();
         check_val("fsk_sel", fsk_sel, exp_fsk[(k - 1) / 4]);
         check_val("fsk_out", mod_out, 37 * k);
         check_val("fsk_strobe", sym_strobe, (k % 4 == 0) ? 1 : 0);
         check_val("fsk_underrun", underrun, (k == 12) ? 1 : 0);
         if (k == 4) sym_in = 2'b01;
         if (k == 8) sym_valid = 1'b0;
      end
      tick();
      check_val("fsk_idle_sel", fsk_sel, 0);
      check_val("fsk_idle_out", mod_out, 0);

      // Mode 3: 2'b10 then 2'b01
      $display("MODE3 10,01 cos=600 sin=200");
      mode = 2'd3; sym_in = 2'b10; cos_in = 12'sd600; sin_in = 12'sd200; sym_valid = 1'b1;
      tick();
      sym_in = 2'b01;
      for (int k = 1; k <= 8; k++) begin
         tick();
         check_val("m3_out", mod_out, (k <= 4) ? m3a : m3b);
         if (k == 4) sym_valid = 1'b0;
      end
      tick();

      // Mode change mid-symbol takes effect only on the next load
      $display("MODE ASK->BPSK at cnt=1");
      mode = 2'd0; sym_in = 2'b01; sin_in = 12'sd300; sym_valid = 1'b1;
      tick();
      tick();
      check_val("mchg_first", mod_out, 300);
      mode = 2'd2; sym_in = 2'b00;
      for (int k = 2; k <= 8; k++) begin
         tick();
         check_val("mchg_out", mod_out, (k <= 4) ? 300 : -300);
         if (k == 4) sym_valid = 1'b0;
      end
      tick();

      // Reset at counter=2 then restart
      $display("RST at cnt=2");
      mode = 2'd0; sym_in = 2'b01; sin_in = 12'sd1000; sym_valid = 1'b1;
      tick();
      sym_valid = 1'b0;
      tick();
      tick();
      check_val("rst_pre_out", mod_out, 1000);
      do_reset();
      tick();
      check_val("rst_post_strobe", sym_strobe, 0);
      check_val("rst_post_out", mod_out, 0);
      sym_valid = 1'b1;
      tick();
      sym_valid = 1'b0;
      check_val("rst_e0_out", mod_out, 0);
      for (int k = 1; k <= 5; k++) begin
         tick();
         check_val("rst_restart_out", mod_out, (k <= 4) ? 1000 : 0);
         check_val("rst_restart_strobe", sym_strobe, (k == 4) ? 1 : 0);
      end
      check_val("rst_restart_underrun", underrun, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
